// File: rtl/gr_rotation_sched_if.sv
// Stream/handshake bundle between the GR rotation sequencer and its neighbours
// (boundary cell, sample source, GR cell, result sink).
interface gr_rotation_sched_if #(
   parameter int DATA_WIDTH = 20,
   parameter int D_WIDTH    = 4,
   parameter int ITER       = 12
);
   logic                  dir_valid;
   logic                  dir_ready;
   logic [ITER-1:0]       dir_word;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  gr_valid;
   logic [DATA_WIDTH-1:0] gr_a;
   logic [D_WIDTH-1:0]    gr_d;
   logic [DATA_WIDTH-1:0] gr_rij;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  row_done;

   modport master (
      output dir_valid, dir_word, s_valid, s_data, gr_rij, m_ready,
      input  dir_ready, s_ready, gr_valid, gr_a, gr_d, m_valid, m_data, row_done
   );

   modport slave (
      input  dir_valid, dir_word, s_valid, s_data, gr_rij, m_ready,
      output dir_ready, s_ready, gr_valid, gr_a, gr_d, m_valid, m_data, row_done
   );
endinterface

// File: rtl/gr_rotation_sched.sv
// Sequencer for one unfolded CORDIC Givens-rotation cell: holds the row's direction
// word, issues one element at a time, slices directions per cycle, returns r_ij.
module gr_rotation_sched #(
   parameter int DATA_WIDTH = 20,
   parameter int D_WIDTH    = 4,
   parameter int ITER       = 12,
   parameter int N_COLS     = 4,
   parameter int GR_LAT     = 1
) (
   input logic              clk,
   input logic              rst_n,
   gr_rotation_sched_if.slave bus
);
   localparam int SLICES = ITER / D_WIDTH;
   localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int LW     = (GR_LAT > 1) ? $clog2(GR_LAT) : 1;
   localparam int CW     = (N_COLS > 1) ? $clog2(N_COLS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ROTATE,
      DRAIN,
      OUT
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [ITER-1:0]       r_dir_reg;
   logic [ITER-1:0]       r_dir_sh;
   logic                  r_dir_loaded;
   logic [SW-1:0]         r_slice_cnt;
   logic [LW-1:0]         r_lat_cnt;
   logic [CW-1:0]         r_col_cnt;
   logic                  r_gr_valid;
   logic [DATA_WIDTH-1:0] r_gr_a;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic                  r_m_valid;
   logic                  r_row_done;

   logic w_dir_fire;
   logic w_s_fire;
   logic w_m_fire;
   logic w_last_slice;
   logic w_last_lat;
   logic w_last_col;
   logic w_slicing;

   assign w_dir_fire   = bus.dir_valid & ~r_dir_loaded;
   assign w_s_fire     = bus.s_valid & (r_state == IDLE) & r_dir_loaded;
   assign w_m_fire     = r_m_valid & bus.m_ready & (r_state == OUT);
   assign w_last_slice = (r_slice_cnt == SW'(SLICES - 1));
   assign w_last_lat   = (r_lat_cnt == LW'(GR_LAT - 1));
   assign w_last_col   = (r_col_cnt == CW'(N_COLS - 1));
   assign w_slicing    = (r_state == ROTATE) || (r_state == DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_s_fire)     w_next_state = ROTATE;
         ROTATE:  if (w_last_slice) w_next_state = DRAIN;
         DRAIN:   if (w_last_lat)   w_next_state = OUT;
         OUT:     if (w_m_fire)     w_next_state = IDLE;
         default:                   w_next_state = IDLE;
      endcase
   end

   // Direction slices come from a private shift copy so dir_reg stays intact for the row;
   // the copy stops shifting on the last slice so DRAIN keeps presenting it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dir_reg    <= '0;
         r_dir_sh     <= '0;
         r_dir_loaded <= 1'b0;
         r_slice_cnt  <= '0;
         r_lat_cnt    <= '0;
         r_col_cnt    <= '0;
         r_gr_valid   <= 1'b0;
         r_gr_a       <= '0;
         r_m_data     <= '0;
         r_m_valid    <= 1'b0;
         r_row_done   <= 1'b0;
      end else begin
         r_gr_valid <= w_s_fire;
         r_row_done <= 1'b0;

         if (w_dir_fire) begin
            r_dir_reg    <= bus.dir_word;
            r_dir_loaded <= 1'b1;
         end

         if (w_s_fire) begin
            r_gr_a      <= bus.s_data;
            r_dir_sh    <= r_dir_reg;
            r_slice_cnt <= '0;
         end

         if (r_state == ROTATE) begin
            r_lat_cnt <= '0;
            if (!w_last_slice) begin
               r_slice_cnt <= r_slice_cnt + SW'(1);
               r_dir_sh    <= r_dir_sh >> D_WIDTH;
            end
         end

         if (r_state == DRAIN) begin
            if (w_last_lat) begin
               r_m_data  <= bus.gr_rij;
               r_m_valid <= 1'b1;
            end else begin
               r_lat_cnt <= r_lat_cnt + LW'(1);
            end
         end

         if (w_m_fire) begin
            r_m_valid <= 1'b0;
            if (w_last_col) begin
               r_col_cnt    <= '0;
               r_dir_loaded <= 1'b0;
               r_row_done   <= 1'b1;
            end else begin
               r_col_cnt <= r_col_cnt + CW'(1);
            end
         end
      end
   end

   assign bus.dir_ready = ~r_dir_loaded;
   assign bus.s_ready   = (r_state == IDLE) & r_dir_loaded;
   assign bus.gr_valid  = r_gr_valid;
   assign bus.gr_a      = r_gr_a;
   assign bus.gr_d      = w_slicing ? r_dir_sh[D_WIDTH-1:0] : '0;
   assign bus.m_valid   = r_m_valid;
   assign bus.m_data    = r_m_data;
   assign bus.row_done  = r_row_done;
endmodule

// File: tb/tb_gr_rotation_sched.sv
// Scoreboard bench for gr_rotation_sched: driver pushes expected r_ij results,
// an independent monitor pops and compares them as the DUT presents them.
module tb_gr_rotation_sched;
   localparam int DW   = 20;
   localparam int DWD  = 4;
   localparam int ITER = 12;
   localparam int NC   = 4;
   localparam int LAT  = 1;

   typedef struct {
      logic [DW-1:0] data;
      int unsigned   rise;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          n_err = 0;
   int          n_chk = 0;
   int          n_push = 0;
   int          n_pop = 0;
   exp_t        sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gr_rotation_sched_if #(.DATA_WIDTH(DW), .D_WIDTH(DWD), .ITER(ITER)) bus ();

   gr_rotation_sched #(
      .DATA_WIDTH(DW), .D_WIDTH(DWD), .ITER(ITER), .N_COLS(NC), .GR_LAT(LAT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   // GR cell stand-in: a value that changes every cycle, so the capture cycle is visible.
   function automatic logic [DW-1:0] gr_model(input int unsigned c);
      return DW'(c * 32'h137 + 32'h400);
   endfunction

   assign bus.gr_rij = gr_model(cyc);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: result data, accept-to-valid latency, and row_done timing.
   bit seen = 0;
   bit exp_rd = 0;
   int rcnt = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         seen   = 0;
         exp_rd = 0;
         rcnt   = 0;
      end else begin
         chk("row_done", bus.row_done, exp_rd);
         if (exp_rd) chk("dir_ready_at_row_done", bus.dir_ready, 1);
         exp_rd = 0;
         if (bus.m_valid) begin
            if (sbq.size() == 0) begin
               chk("m_valid_unexpected", bus.m_valid, 0);
            end else begin
               if (!seen) begin
                  chk("m_latency", cyc, sbq[0].rise);
                  seen = 1;
               end
               chk("m_data", bus.m_data, sbq[0].data);
               if (bus.m_ready) begin
                  void'(sbq.pop_front());
                  n_pop++;
                  seen = 0;
                  rcnt++;
                  if (rcnt == NC) begin
                     exp_rd = 1;
                     rcnt   = 0;
                  end
               end
            end
         end
      end
   end

   task automatic load_dir(input logic [ITER-1:0] w);
      bit ok = 0;
      @(posedge clk); #1;
      bus.dir_valid = 1'b1;
      bus.dir_word  = w;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.dir_ready) begin
            ok = 1;
            break;
         end
      end
      chk("dir_accept", ok, 1);
      @(posedge clk); #1;
      bus.dir_valid = 1'b0;
   endtask

   task automatic send_elem(input logic [DW-1:0] d, input logic [ITER-1:0] w);
      bit          ok = 0;
      int unsigned c;
      int          sl;
      @(posedge clk); #1;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.s_ready) begin
            ok = 1;
            break;
         end
      end
      chk("s_accept", ok, 1);
      c = cyc;
      if (ok) begin
         sbq.push_back('{gr_model(c + 4), c + 5});
         n_push++;
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      if (ok) begin
         for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            sl = (k < 4) ? k - 1 : 2;
            chk("gr_valid", bus.gr_valid, (k == 1) ? 1 : 0);
            chk("gr_a", bus.gr_a, d);
            chk("gr_d", bus.gr_d, w[sl*DWD +: DWD]);
         end
      end
   endtask

   task automatic wait_drain();
      int i = 0;
      while (sbq.size() != 0 && i < 60) begin
         @(negedge clk);
         i++;
      end
      chk("drain", sbq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish");
      $fatal(1);
   end

   initial begin
      bit rd_ok;
      bus.dir_valid = 1'b0;
      bus.dir_word  = '0;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.m_ready   = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_dir_ready", bus.dir_ready, 1);
      chk("rst_gr_valid", bus.gr_valid, 0);
      chk("rst_gr_d", bus.gr_d, 0);
      chk("rst_gr_a", bus.gr_a, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_row_done", bus.row_done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // T6: element offered with no direction word
      bus.s_valid = 1'b1;
      bus.s_data  = 20'h12345;
      repeat (6) begin
         @(negedge clk);
         chk("nodir_s_ready", bus.s_ready, 0);
         chk("nodir_gr_valid", bus.gr_valid, 0);
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;

      // T1: slices C,5,A; result sampled at t+4, valid at t+5
      load_dir(12'hA5C);
      send_elem(20'h00400, 12'hA5C);
      wait_drain();

      // T2/T3: second word offered while loaded; taken only at row end
      @(posedge clk); #1;
      bus.dir_valid = 1'b1;
      bus.dir_word  = 12'h3E7;
      @(negedge clk);
      chk("busy_dir_ready", bus.dir_ready, 0);
      send_elem(20'hFFC00, 12'hA5C);
      send_elem(20'h7FFFF, 12'hA5C);
      send_elem(20'h80000, 12'hA5C);
      rd_ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.row_done) begin
            rd_ok = 1;
            break;
         end
      end
      chk("row_done_seen", rd_ok, 1);
      @(posedge clk); #1;
      bus.dir_valid = 1'b0;
      @(negedge clk);
      chk("new_dir_loaded", bus.dir_ready, 0);

      // T4: result held under back-pressure; second element offered but refused
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      send_elem(20'h00ABC, 12'h3E7);
      @(posedge clk); #1;
      bus.s_valid = 1'b1;
      bus.s_data  = 20'h55555;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_m_valid", bus.m_valid, 1);
         chk("hold_s_ready", bus.s_ready, 0);
         chk("hold_gr_valid", bus.gr_valid, 0);
         if (i < 9) @(posedge clk);
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      wait_drain();

      // T5: reset during ROTATE slice 1
      @(posedge clk); #1;
      bus.s_valid = 1'b1;
      bus.s_data  = 20'h0F0F0;
      rd_ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.s_ready) begin
            rd_ok = 1;
            break;
         end
      end
      chk("t5_accept", rd_ok, 1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
      chk("t5_slice1", bus.gr_d, 4'hE);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_gr_valid", bus.gr_valid, 0);
      chk("t5_gr_d", bus.gr_d, 0);
      chk("t5_m_valid", bus.m_valid, 0);
      chk("t5_s_ready", bus.s_ready, 0);
      chk("t5_dir_ready", bus.dir_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.s_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t5_post_s_ready", bus.s_ready, 0);
         chk("t5_post_gr_valid", bus.gr_valid, 0);
         chk("t5_post_m_valid", bus.m_valid, 0);
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;

      load_dir(12'h81F);
      send_elem(20'h00001, 12'h81F);
      wait_drain();

      chk("results_consumed", n_pop, n_push);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
